mac_sequencer: RTL

- Initiator-side controller for the opcode-driven MAC datapath. Drives that unit's data_in and opcode inputs, and reads back its data_out.
- Accepts a job (start + pair count) and a stream of (a,b) operand pairs. For each pair it issues the MAC opcode sequence, then reads the 2*DATA_WIDTH accumulator as MSW then LSW. It presents the result on a valid/ready port.
- Sits between the SAP-1 control path and the mac instance, sharing clk and a_reset_n.

---
 rtl/mac_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - job sequencer driving the opcode-driven MAC datapath
module mac_sequencer #(
    parameter int          DATA_WIDTH = 8,
    parameter int          LEN_WIDTH  = 8,
    parameter logic [3:0]  OP_IDLE    = 4'hF,
    // Must track the MAC_* encodings of the mac instance.
    parameter logic [3:0]  MAC_RESET  = 4'h0,
    parameter logic [3:0]  MAC_REGA   = 4'h1,
    parameter logic [3:0]  MAC_REGB   = 4'h2,
    parameter logic [3:0]  MAC_MULT   = 4'h3,
    parameter logic [3:0]  MAC_ACC    = 4'h4,
    parameter logic [3:0]  MAC_MSW    = 4'h5,
    parameter logic [3:0]  MAC_LSW    = 4'h6
) (
    input  logic                      clk,
    input  logic                      a_reset_n,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_a,
    input  logic [DATA_WIDTH-1:0]     in_b,
    output logic [3:0]                mac_opcode,
    output logic [DATA_WIDTH-1:0]     mac_data,
    input  logic [DATA_WIDTH-1:0]     mac_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*DATA_WIDTH-1:0]   res_data,
    output logic                      busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_A,
        S_LOAD_B,
        S_MULT,
        S_ACC,
        S_RD_MSW,
        S_RD_LSW,
        S_CAP_LSW,
        S_RESULT
    } state_t;

    state_t                    state_q, state_d;
    logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]     b_hold_q, b_hold_d;
    logic [DATA_WIDTH-1:0]     msw_q, msw_d;
    logic [2*DATA_WIDTH-1:0]   res_q, res_d;
    logic [LEN_WIDTH-1:0]      remaining_dec;

    assign remaining_dec = remaining_q - LEN_WIDTH'(1);
    assign res_data      = res_q;
    assign busy          = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        b_hold_d    = b_hold_q;
        msw_d       = msw_q;
        res_d       = res_q;
        mac_opcode  = OP_IDLE;
        mac_data    = '0;
        in_ready    = 1'b0;
        res_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_CLEAR;
                    remaining_d = len;
                    b_hold_d    = '0;
                end
            end
            S_CLEAR: begin
                mac_opcode = MAC_RESET;
                state_d    = (remaining_q != '0) ? S_LOAD_A : S_RD_MSW;
            end
            S_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mac_opcode = MAC_REGA;
                    mac_data   = in_a;
                    b_hold_d   = in_b;
                    state_d    = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                mac_opcode = MAC_REGB;
                mac_data   = b_hold_q;
                state_d    = S_MULT;
            end
            S_MULT: begin
                mac_opcode = MAC_MULT;
                state_d    = S_ACC;
            end
            S_ACC: begin
                mac_opcode  = MAC_ACC;
                remaining_d = remaining_dec;
                state_d     = (remaining_dec != '0) ? S_LOAD_A : S_RD_MSW;
            end
            S_RD_MSW: begin
                mac_opcode = MAC_MSW;
                state_d    = S_RD_LSW;
            end
            // The mac registers its read-back, so each word lands one state late.
            S_RD_LSW: begin
                mac_opcode = MAC_LSW;
                msw_d      = mac_result;
                state_d    = S_CAP_LSW;
            end
            S_CAP_LSW: begin
                res_d   = {msw_q, mac_result};
                state_d = S_RESULT;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            b_hold_q    <= '0;
            msw_q       <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            b_hold_q    <= b_hold_d;
            msw_q       <= msw_d;
            res_q       <= res_d;
        end
    end

endmodule
